// File: rtl/spm_pkg.sv
// Shared types and constants for the signed serial-parallel multiplier arbiter.
package spm_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned NUM_REQ       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/spm_arbiter_rr.sv
// Two-way round-robin grant: the pointer names the requester with priority.
module rr_arbiter2
    import spm_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_c
);

    always_comb begin
        grant_c = '0;
        if (en) begin
            if (ptr == 1'b0) begin
                if (req[0])      grant_c = 2'b01;
                else if (req[1]) grant_c = 2'b10;
            end else begin
                if (req[1])      grant_c = 2'b10;
                else if (req[0]) grant_c = 2'b01;
            end
        end
    end

endmodule

// File: rtl/spm_arbiter.sv
// Shares one serial-parallel multiplier between two requesters (IDLE/ISSUE/WAIT/RESP).
// Define SPM_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module spm_arbiter
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [WIDTH-1:0]     req_a0,
    input  logic [WIDTH-1:0]     req_b0,
    input  logic [WIDTH-1:0]     req_a1,
    input  logic [WIDTH-1:0]     req_b1,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic                 mul_done
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t             state, state_d;
    logic               ptr, ptr_d;
    logic               gnt, gnt_d;
    logic [WIDTH-1:0]   a_d, b_d;
    logic [PW-1:0]      prod_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic               mul_start_d;
    logic [NUM_REQ-1:0] grant_c;
    logic               arb_en_c;

`ifdef SPM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign rsp_err        = 1'b0;
`endif

    // Grants are only offered in IDLE and never while reset is being applied
    assign arb_en_c = (state == IDLE) && !rst;

    rr_arbiter2 u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en_c),
        .grant_c (grant_c)
    );

    assign req_ready = grant_c;

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        gnt_d       = gnt;
        a_d         = mul_a;
        b_d         = mul_b;
        prod_d      = rsp_product;
        rsp_valid_d = '0;
        mul_start_d = 1'b0;
`ifdef SPM_ARB_TIMEOUT_EN
        cnt_d       = cnt;
        err_d       = rsp_err;
`endif
        case (state)
            IDLE: begin
                if (grant_c != '0) begin
                    gnt_d   = grant_c[1];
                    a_d     = grant_c[1] ? req_a1 : req_a0;
                    b_d     = grant_c[1] ? req_b1 : req_b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SPM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (mul_done) begin
                    prod_d  = mul_product;
                    state_d = RESP;
`ifdef SPM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready[gnt]) begin
                    ptr_d   = ~gnt;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered strobes follow the state being entered
        if (state_d == RESP) rsp_valid_d[gnt_d] = 1'b1;
        mul_start_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            gnt         <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
            rsp_valid   <= '0;
            mul_start   <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            gnt         <= gnt_d;
            mul_a       <= a_d;
            mul_b       <= b_d;
            rsp_product <= prod_d;
            rsp_valid   <= rsp_valid_d;
            mul_start   <= mul_start_d;
        end
    end

`ifdef SPM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            rsp_err <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_spm_arbiter.sv
// Scoreboard bench for spm_arbiter with a behavioural multiplier of programmable latency.
module tb_spm_arbiter;
    import spm_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned PW  = 2 * W;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [W-1:0]  req_a0, req_b0, req_a1, req_b1, mul_a, mul_b;
    logic [PW-1:0] rsp_product, mul_product;
    logic          rsp_err, mul_start, mul_done;

    always #5 clk = ~clk;

    spm_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done)
    );

    typedef struct { logic idx; logic [PW-1:0] prod; logic err; int lat; } exp_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;

    exp_t          sb[$];
    op_t           stim0[$], stim1[$];
    logic          idx_log[$];
    logic [PW-1:0] prod_log[$];
    int            errors = 0, checks = 0, cyc = 0;
    int            done_cnt = 0, hs_cnt0 = 0, hs_cnt1 = 0;
    logic [PW-1:0] last_prod;
    logic          last_err;
    int            mul_delay = 2;
    logic          suppress = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] x, y;
        x = {{W{a[W-1]}}, a};
        y = {{W{b[W-1]}}, b};
        return PW'(x * y);
    endfunction

    // Behavioural multiplier: done pulses mul_delay cycles after start
    initial begin : mul_model
        int            mcnt;
        logic [PW-1:0] mprod;
        mcnt = 0; mprod = '0; mul_done = 1'b0; mul_product = '0;
        forever begin
            @(negedge clk);
            mul_done    = 1'b0;
            mul_product = PW'($urandom);
            if (rst) begin
                mcnt = 0;
            end else begin
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0 && !suppress) begin
                        mul_done    = 1'b1;
                        mul_product = mprod;
                    end
                end
                if (mul_start) begin
                    mcnt  = mul_delay;
                    mprod = mul_ref(mul_a, mul_b);
                end
            end
        end
    end

    // Requester driver: keeps valid high while a stimulus queue has entries
    initial begin : driver
        int seen0, seen1;
        op_t op;
        seen0 = 0; seen1 = 0;
        req_valid = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        forever begin
            @(posedge clk); #1;
            if (hs_cnt0 != seen0) begin seen0 = hs_cnt0; req_valid[0] = 1'b0; end
            if (hs_cnt1 != seen1) begin seen1 = hs_cnt1; req_valid[1] = 1'b0; end
            if (!req_valid[0] && stim0.size() > 0) begin
                op = stim0.pop_front(); req_a0 = op.a; req_b0 = op.b; req_valid[0] = 1'b1;
            end
            if (!req_valid[1] && stim1.size() > 0) begin
                op = stim1.pop_front(); req_a1 = op.a; req_b1 = op.b; req_valid[1] = 1'b1;
            end
        end
    end

    // Monitor: round-robin model, scoreboard push on handshake, pop on response
    initial begin : monitor
        logic         exp_ptr, busy, start_due, resp_seen, g;
        logic [1:0]   eg;
        logic [W-1:0] hs_a, hs_b;
        int           hs_cyc;
        exp_t         e;
        exp_ptr = 0; busy = 0; start_due = 0; resp_seen = 0; hs_cyc = 0; hs_a = '0; hs_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                exp_ptr = 0; busy = 0; start_due = 0; resp_seen = 0;
            end else begin
                check_eq("mul_start", 32'(mul_start), 32'(start_due));
                if (start_due) begin
                    check_eq("mul_a", 32'(mul_a), 32'(hs_a));
                    check_eq("mul_b", 32'(mul_b), 32'(hs_b));
                end
                start_due = 0;
                if (busy) begin
                    check_eq("ready_busy", 32'(req_ready), 32'(0));
                end else if (req_valid != '0) begin
                    if (exp_ptr == 1'b0) eg = req_valid[0] ? 2'b01 : 2'b10;
                    else                 eg = req_valid[1] ? 2'b10 : 2'b01;
                    check_eq("grant", 32'(req_ready), 32'(eg));
                    if ((req_ready & req_valid) != '0) begin
                        g    = req_ready[1];
                        hs_a = g ? req_a1 : req_a0;
                        hs_b = g ? req_b1 : req_b0;
                        e.idx  = g;
                        e.prod = suppress ? '0 : mul_ref(hs_a, hs_b);
                        e.err  = suppress;
                        e.lat  = suppress ? int'(TMO) + 2 : mul_delay + 2;
                        sb.push_back(e);
                        if (g) hs_cnt1++; else hs_cnt0++;
                        busy = 1; start_due = 1; hs_cyc = cyc;
                    end
                end
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        check_eq("rsp_spurious", 32'(rsp_valid), 32'(0));
                    end else begin
                        e = sb[0];
                        if (!resp_seen) begin
                            check_eq("latency", 32'(cyc - hs_cyc), 32'(e.lat));
                            resp_seen = 1;
                        end
                        check_eq("rsp_valid", 32'(rsp_valid), e.idx ? 32'd2 : 32'd1);
                        check_eq("rsp_product", 32'(rsp_product), 32'(e.prod));
                        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (rsp_ready[e.idx]) begin
                            void'(sb.pop_front());
                            idx_log.push_back(e.idx);
                            prod_log.push_back(rsp_product);
                            last_prod = rsp_product;
                            last_err  = rsp_err;
                            exp_ptr   = ~e.idx;
                            busy = 0; resp_seen = 0;
                            done_cnt++;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin @(negedge clk); k++; end
        if (done_cnt < target) check_eq("wait_done", 32'(done_cnt), 32'(target));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_req_ready"}, 32'(req_ready), 32'(0));
        check_eq({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        check_eq({pfx, "_mul_start"}, 32'(mul_start), 32'(0));
        check_eq({pfx, "_mul_a"}, 32'(mul_a), 32'(0));
        check_eq({pfx, "_mul_b"}, 32'(mul_b), 32'(0));
        check_eq({pfx, "_rsp_product"}, 32'(rsp_product), 32'(0));
        check_eq({pfx, "_rsp_err"}, 32'(rsp_err), 32'(0));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int            base, base2, k;
        logic [PW-1:0] p0;
        rst = 1'b1; rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Single request: -3 * 5
        mul_delay = 2; base = done_cnt;
        stim0.push_back('{8'hFD, 8'h05});
        wait_done(base + 1, 100);
        check_eq("single_prod", 32'(last_prod), 32'h0000_FFF1);

        // Simultaneous requests straight after reset
        do_reset();
        mul_delay = 3; base = done_cnt;
        stim0.push_back('{8'h7F, 8'h80});
        stim1.push_back('{8'h80, 8'h80});
        wait_done(base + 2, 200);
        if (idx_log.size() >= base + 2) begin
            check_eq("simul_first_idx", 32'(idx_log[base]), 32'(0));
            check_eq("simul_first_prod", 32'(prod_log[base]), 32'h0000_C080);
            check_eq("simul_second_idx", 32'(idx_log[base + 1]), 32'(1));
            check_eq("simul_second_prod", 32'(prod_log[base + 1]), 32'h0000_4000);
        end

        // Fairness with both valids held high
        mul_delay = 1; base = done_cnt;
        for (int i = 0; i < 2; i++) begin
            stim0.push_back('{W'($urandom), W'($urandom)});
            stim1.push_back('{W'($urandom), W'($urandom)});
        end
        wait_done(base + 4, 300);
        for (int i = 0; i < 4; i++)
            if (idx_log.size() > base + i)
                check_eq($sformatf("fair_idx%0d", i), 32'(idx_log[base + i]), 32'(i % 2));

        // Backpressure in RESP for 10 cycles
        mul_delay = 4; base = done_cnt;
        @(posedge clk); #1 rsp_ready = 2'b00;
        stim1.push_back('{8'hC3, 8'h17});
        k = 0;
        while (rsp_valid == '0 && k < 50) begin @(negedge clk); k++; end
        check_eq("bp_reached_resp", 32'(rsp_valid), 32'd2);
        p0 = rsp_product;
        stim0.push_back('{8'h21, 8'hF0});
        repeat (10) @(negedge clk);
        check_eq("bp_hold_valid", 32'(rsp_valid), 32'd2);
        check_eq("bp_hold_prod", 32'(rsp_product), 32'(p0));
        @(posedge clk); #1 rsp_ready = 2'b11;
        wait_done(base + 2, 200);
        if (idx_log.size() >= base + 2) begin
            check_eq("bp_first_idx", 32'(idx_log[base]), 32'(1));
            check_eq("bp_second_idx", 32'(idx_log[base + 1]), 32'(0));
        end

        // Reset in the middle of WAIT
        mul_delay = 30; base = done_cnt;
        stim0.push_back('{8'h5A, 8'hA5});
        k = 0;
        while (!mul_start && k < 50) begin @(negedge clk); k++; end
        check_eq("rst_saw_start", 32'(mul_start), 32'(1));
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);
        check_reset_outputs("midrst");
        mul_delay = 2; base2 = done_cnt;
        check_eq("midrst_discard", 32'(base2), 32'(base));
        stim1.push_back('{8'h0F, 8'hF3});
        stim0.push_back('{8'h80, 8'h7F});
        wait_done(base2 + 2, 200);
        if (idx_log.size() >= base2 + 2) begin
            check_eq("midrst_first_idx", 32'(idx_log[base2]), 32'(0));
            check_eq("midrst_second_idx", 32'(idx_log[base2 + 1]), 32'(1));
        end

`ifdef SPM_ARB_TIMEOUT_EN
        // Multiplier never answers: abort after TMO wait cycles
        suppress = 1'b1; base = done_cnt;
        stim0.push_back('{8'h11, 8'h22});
        wait_done(base + 1, 200);
        check_eq("timeout_err", 32'(last_err), 32'(1));
        check_eq("timeout_prod", 32'(last_prod), 32'(0));
        suppress = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
